// File: rtl/pc_pkg.sv
// pc_pkg: shared defaults and the next-PC source encoding for the fetch
// program-counter generator (pc_gen) and its return-address stack.
//   XLEN_DEF        PC width in bits
//   INC_DEF         sequential fetch increment in bytes
//   ALIGN_BITS_DEF  low PC bits that must be zero
//   RAS_DEPTH_DEF   return-address-stack entries (power of 2)
//   pc_src_e        which source produces the next PC, highest priority first
package pc_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int INC_DEF        = 4;
    localparam int ALIGN_BITS_DEF = 2;
    localparam int RAS_DEPTH_DEF  = 4;

    typedef enum logic [2:0] {
        SRC_TRAP,
        SRC_REDIR,
        SRC_RAS,
        SRC_SEQ,
        SRC_HOLD
    } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular LIFO of return addresses.
//   clk, rst_n    clock and synchronous active-low reset (empties the stack)
//   i_clear       empty the stack (takes priority over the operations below)
//   i_push        push i_data; when full the oldest entry is overwritten
//   i_pop         discard the top entry (ignored when empty)
//   i_replace     overwrite the top entry with i_data, count unchanged
//   i_data        address to push or replace with
//   o_top         current top entry (undefined when empty)
//   o_empty       count == 0
//   o_full        count == DEPTH
module ras_stack
    import pc_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clear,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_replace,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_top,
    output logic            o_empty,
    output logic            o_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_ptr_up;
    logic [PTR_W-1:0] w_ptr_dn;

    // DEPTH is a power of 2, so pointer arithmetic wraps around the ring for
    // free; a push onto a full stack lands on the oldest slot.
    assign w_ptr_up = r_ptr + PTR_W'(1);
    assign w_ptr_dn = r_ptr - PTR_W'(1);

    assign o_top   = r_mem[r_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_push) begin
            r_ptr <= w_ptr_up;
            if (!o_full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (i_pop && !o_empty) begin
            r_ptr   <= w_ptr_dn;
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage needs no reset; the count alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (rst_n && !i_clear) begin
            if (i_push) begin
                r_mem[w_ptr_up] <= i_data;
            end else if (i_replace) begin
                r_mem[r_ptr] <= i_data;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator.
// Holds the fetch PC and picks the next one from trap vector, execute-stage
// redirect, return-address-stack pop or sequential PC+INC (in that priority).
//   clk, rst_n      clock and synchronous active-low reset
//   stall_i         hold the PC; sequential advance and RAS ops blocked
//   fetch_ready_i   instruction memory accepts pc_o this cycle
//   redirect_i      taken branch/jump, target redirect_pc_i
//   trap_i          exception/interrupt entry, target trap_vec_i; clears RAS
//   call_i, ret_i   accepted instruction is a call / return
//   pc_o            current fetch PC
//   pc_plus_inc_o   pc_o + INC (wraps)
//   fetch_valid_o   pc_o is a valid fetch request
//   misalign_o      one-cycle pulse: last loaded target had low bits set
//   ras_empty_o     RAS holds no entries
//   ras_full_o      RAS holds RAS_DEPTH entries
module pc_gen
    import pc_pkg::*;
#(
    parameter int               XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int               INC          = INC_DEF,
    parameter int               ALIGN_BITS   = ALIGN_BITS_DEF,
    parameter int               RAS_DEPTH    = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            fetch_ready_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_inc_o,
    output logic            fetch_valid_o,
    output logic            misalign_o,
    output logic            ras_empty_o,
    output logic            ras_full_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    logic [XLEN-1:0] r_pc;
    logic            r_valid;
    logic            r_misalign;

    logic            w_accept;
    logic            w_ras_op;
    logic            w_push;
    logic            w_pop;
    logic            w_replace;
    logic [XLEN-1:0] w_ras_top;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_next;
    logic            w_mis_next;
    pc_src_e         w_src;

    assign pc_o          = r_pc;
    assign pc_plus_inc_o = r_pc + XLEN'(INC);
    assign fetch_valid_o = r_valid;
    assign misalign_o    = r_misalign;

    assign w_accept = r_valid & fetch_ready_i & ~stall_i;

    // Stack traffic only for an accepted instruction that is not being
    // overtaken by a trap or redirect. call+ret on a non-empty stack swaps
    // the top in place; on an empty stack it degrades to a plain call.
    assign w_ras_op  = w_accept & ~trap_i & ~redirect_i;
    assign w_push    = w_ras_op & call_i & (~ret_i | ras_empty_o);
    assign w_replace = w_ras_op & call_i & ret_i & ~ras_empty_o;
    assign w_pop     = w_ras_op & ~call_i & ret_i & ~ras_empty_o;

    always_comb begin
        w_src      = SRC_HOLD;
        w_target   = '0;
        w_pc_next  = r_pc;
        w_mis_next = 1'b0;
        if (trap_i) begin
            w_src = SRC_TRAP;
        end else if (redirect_i) begin
            w_src = SRC_REDIR;
        end else if (w_accept && ret_i && !ras_empty_o) begin
            w_src = SRC_RAS;
        end else if (w_accept) begin
            w_src = SRC_SEQ;
        end

        case (w_src)
            SRC_TRAP:  w_target = trap_vec_i;
            SRC_REDIR: w_target = redirect_pc_i;
            SRC_RAS:   w_target = w_ras_top;
            default:   w_target = '0;
        endcase

        case (w_src)
            SRC_TRAP, SRC_REDIR, SRC_RAS: begin
                w_pc_next  = w_target & ~ALIGN_MASK;
                w_mis_next = |(w_target & ALIGN_MASK);
            end
            SRC_SEQ:  w_pc_next = pc_plus_inc_o;
            default:  w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_VECTOR;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_valid    <= 1'b1;
            r_misalign <= w_mis_next;
        end
    end

    ras_stack #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (trap_i),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_replace (w_replace),
        .i_data    (pc_plus_inc_o),
        .o_top     (w_ras_top),
        .o_empty   (ras_empty_o),
        .o_full    (ras_full_o)
    );

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed stimulus for pc_gen with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_pc_gen;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        ready = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        trap = 1'b0;
    logic [31:0] trap_vec = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;

    logic [31:0] pc_o;
    logic [31:0] pc_plus_inc_o;
    logic        fetch_valid_o;
    logic        misalign_o;
    logic        ras_empty_o;
    logic        ras_full_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc    = 32'h100;
    logic        m_valid = 1'b0;
    logic        m_mis   = 1'b0;
    logic [31:0] ras_q[$];
    logic        m_acc;
    logic        m_load;
    logic [31:0] m_tgt;
    logic [31:0] m_next;

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h100),
        .INC          (4),
        .ALIGN_BITS   (2),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall),
        .fetch_ready_i (ready),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .trap_i        (trap),
        .trap_vec_i    (trap_vec),
        .call_i        (call),
        .ret_i         (ret),
        .pc_o          (pc_o),
        .pc_plus_inc_o (pc_plus_inc_o),
        .fetch_valid_o (fetch_valid_o),
        .misalign_o    (misalign_o),
        .ras_empty_o   (ras_empty_o),
        .ras_full_o    (ras_full_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: plain next-PC rules with the RAS as a bounded queue of addresses.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc    = 32'h100;
            m_valid = 1'b0;
            m_mis   = 1'b0;
            ras_q.delete();
        end else begin
            m_acc  = m_valid && ready && !stall;
            m_load = 1'b0;
            m_tgt  = '0;
            m_next = m_pc;
            if (trap) begin
                m_tgt = trap_vec; m_load = 1'b1;
                ras_q.delete();
            end else if (redirect) begin
                m_tgt = redirect_pc; m_load = 1'b1;
            end else if (m_acc) begin
                if (ret && ras_q.size() > 0) begin
                    m_tgt = ras_q[ras_q.size()-1]; m_load = 1'b1;
                    if (call) ras_q[ras_q.size()-1] = m_pc + 32'd4;
                    else void'(ras_q.pop_back());
                end else begin
                    m_next = m_pc + 32'd4;
                    if (call) begin
                        if (ras_q.size() == DEPTH) void'(ras_q.pop_front());
                        ras_q.push_back(m_pc + 32'd4);
                    end
                end
            end
            if (m_load) begin
                m_mis  = (m_tgt % 4) != 0;
                m_next = m_tgt - (m_tgt % 4);
            end else begin
                m_mis = 1'b0;
            end
            m_pc    = m_next;
            m_valid = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("pc_o", pc_o, m_pc);
        check("pc_plus_inc_o", pc_plus_inc_o, m_pc + 32'd4);
        check("fetch_valid_o", 32'(fetch_valid_o), 32'(m_valid));
        check("misalign_o", 32'(misalign_o), 32'(m_mis));
        check("ras_empty_o", 32'(ras_empty_o), 32'(ras_q.size() == 0));
        check("ras_full_o", 32'(ras_full_o), 32'(ras_q.size() == DEPTH));
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic jump(input logic [31:0] addr);
        redirect = 1'b1; redirect_pc = addr;
        cyc();
        redirect = 1'b0;
    endtask

    task automatic do_call();
        call = 1'b1;
        cyc();
        call = 1'b0;
    endtask

    initial begin
        // 1. reset and sequential fetch
        cyc(2);
        check("lit_reset_valid", 32'(fetch_valid_o), 32'd0);
        check("lit_reset_pc", pc_o, 32'h100);
        check("lit_reset_empty", 32'(ras_empty_o), 32'd1);
        rst_n = 1'b1;
        cyc();
        check("lit_first_pc", pc_o, 32'h100);
        check("lit_first_valid", 32'(fetch_valid_o), 32'd1);
        cyc();
        check("lit_seq1", pc_o, 32'h104);
        cyc();
        check("lit_seq2", pc_o, 32'h108);

        // 2. stall holds PC and blocks RAS; redirect overrides stall
        jump(32'h20);
        check("lit_jump20", pc_o, 32'h20);
        stall = 1'b1; call = 1'b1;
        cyc(3);
        check("lit_stall_pc", pc_o, 32'h20);
        check("lit_stall_noras", 32'(ras_empty_o), 32'd1);
        call = 1'b0;
        jump(32'h400);
        check("lit_stall_redir", pc_o, 32'h400);
        stall = 1'b0;
        do_call();
        check("lit_call_pc", pc_o, 32'h404);
        check("lit_call_nonempty", 32'(ras_empty_o), 32'd0);
        ready = 1'b0;
        cyc();
        check("lit_notready", pc_o, 32'h404);
        ready = 1'b1;

        // 3. trap beats redirect and clears RAS
        trap = 1'b1; trap_vec = 32'h80; redirect = 1'b1; redirect_pc = 32'h200;
        cyc();
        trap = 1'b0; redirect = 1'b0;
        check("lit_trap_pc", pc_o, 32'h80);
        check("lit_trap_empty", 32'(ras_empty_o), 32'd1);

        // 4. nested calls and returns
        jump(32'h10);
        do_call();
        jump(32'h50);
        do_call();
        check("lit_call2_pc", pc_o, 32'h54);
        ret = 1'b1;
        cyc();
        check("lit_ret1", pc_o, 32'h54);
        cyc();
        check("lit_ret2", pc_o, 32'h14);
        cyc();
        check("lit_ret_empty_seq", pc_o, 32'h18);
        check("lit_ret_empty", 32'(ras_empty_o), 32'd1);
        ret = 1'b0;

        // 5. overflow drops the oldest entry
        for (int i = 0; i <= DEPTH; i++) begin
            jump(32'(i * 16));
            do_call();
        end
        check("lit_ovf_full", 32'(ras_full_o), 32'd1);
        ret = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            cyc();
            check("lit_ovf_ret", pc_o, 32'h44 - 32'(k * 16));
        end
        ret = 1'b0;
        check("lit_ovf_empty", 32'(ras_empty_o), 32'd1);

        // call+ret together replaces the top
        jump(32'h200);
        do_call();
        jump(32'h300);
        call = 1'b1; ret = 1'b1;
        cyc();
        check("lit_swap_pc", pc_o, 32'h204);
        call = 1'b0;
        cyc();
        check("lit_swap_ret", pc_o, 32'h304);
        ret = 1'b0;
        check("lit_swap_empty", 32'(ras_empty_o), 32'd1);

        // 6. misalignment and wraparound
        jump(32'h103);
        check("lit_mis_pc", pc_o, 32'h100);
        check("lit_mis_pulse", 32'(misalign_o), 32'd1);
        cyc();
        check("lit_mis_clear", 32'(misalign_o), 32'd0);
        check("lit_mis_seq", pc_o, 32'h104);
        trap = 1'b1; trap_vec = 32'h81;
        cyc();
        trap = 1'b0;
        check("lit_trap_mis", pc_o, 32'h80);
        check("lit_trap_mis_pulse", 32'(misalign_o), 32'd1);
        jump(32'hFFFF_FFFC);
        check("lit_wrap_inc", pc_plus_inc_o, 32'h0);
        cyc();
        check("lit_wrap_pc", pc_o, 32'h0);

        // reset wins over pending stall/redirect
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h500; rst_n = 1'b0;
        cyc();
        check("lit_rst_pc", pc_o, 32'h100);
        check("lit_rst_valid", 32'(fetch_valid_o), 32'd0);
        rst_n = 1'b1; stall = 1'b0; redirect = 1'b0;
        cyc();
        check("lit_rst_rel_pc", pc_o, 32'h100);
        check("lit_rst_rel_valid", 32'(fetch_valid_o), 32'd1);
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
